// File: rtl/connect4_pkg.sv
// -----------------------------------------------------------------------------
// connect4_pkg
// Shared definitions for the Connect4 column slot allocator.
//   - DEF_NUM_COLS / DEF_NUM_ROWS : default board geometry (7 x 6)
//   - MAX_COLS / MAX_IDX_W        : widest column select the helpers handle
//   - op_e                        : decoded request type
//   - onehot_idx_t                : column index plus a one-hot valid bit
//   - onehot_to_idx()             : one-hot column select -> binary index
// -----------------------------------------------------------------------------
package connect4_pkg;

  localparam int DEF_NUM_COLS = 7;
  localparam int DEF_NUM_ROWS = 6;

  // Column selects are zero-extended to this width before decoding, so one
  // helper serves every legal NUM_COLS (2..16).
  localparam int MAX_COLS  = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_DROP,
    OP_UNDO,
    OP_BAD
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } onehot_idx_t;

  // valid is set only when exactly one bit is high; idx is then that bit's
  // position. For zero or multiple bits idx carries no meaning.
  function automatic onehot_idx_t onehot_to_idx(input logic [MAX_COLS-1:0] vec);
    onehot_idx_t res;
    int unsigned ones;
    res.valid = 1'b0;
    res.idx   = '0;
    ones      = 0;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (vec[i]) begin
        res.idx = MAX_IDX_W'(i);
        ones++;
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/column_slot_allocator_if.sv
// -----------------------------------------------------------------------------
// column_slot_allocator_if
// Request/response bundle between the column-select logic (master) and the
// slot allocator (slave).
//   Requests  (master -> slave): drop_req, undo_req, clear_board, sel_col
//   Responses (slave -> master): rsp_valid, rsp_ok, cell_index, cell_row,
//                                cell_col, col_full, board_full
// Geometry parameters must match those of the allocator instance.
// -----------------------------------------------------------------------------
interface column_slot_allocator_if
  import connect4_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int NUM_ROWS = DEF_NUM_ROWS
);

  localparam int IDX_W = $clog2(NUM_COLS * NUM_ROWS);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);

  logic                drop_req;
  logic                undo_req;
  logic                clear_board;
  logic [NUM_COLS-1:0] sel_col;

  logic                rsp_valid;
  logic                rsp_ok;
  logic [IDX_W-1:0]    cell_index;
  logic [ROW_W-1:0]    cell_row;
  logic [COL_W-1:0]    cell_col;
  logic [NUM_COLS-1:0] col_full;
  logic                board_full;

  modport master (
    output drop_req, undo_req, clear_board, sel_col,
    input  rsp_valid, rsp_ok, cell_index, cell_row, cell_col, col_full, board_full
  );

  modport slave (
    input  drop_req, undo_req, clear_board, sel_col,
    output rsp_valid, rsp_ok, cell_index, cell_row, cell_col, col_full, board_full
  );

endinterface

// File: rtl/column_height_counter.sv
// -----------------------------------------------------------------------------
// column_height_counter
// Fill height of one board column: a saturating up/down counter in 0..NUM_ROWS.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, height -> 0
//   clear  : synchronous clear, same effect as reset
//   inc    : add one disc (ignored when full)
//   dec    : remove one disc (ignored when empty)
//   height : current number of discs in the column
//   full   : height == NUM_ROWS
//   empty  : height == 0
// -----------------------------------------------------------------------------
module column_height_counter
  import connect4_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int HGT_W    = $clog2(NUM_ROWS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [HGT_W-1:0] height,
  output logic             full,
  output logic             empty
);

  assign full  = (height == HGT_W'(NUM_ROWS));
  assign empty = (height == '0);

  // NOTE: the height is a handful of flops, so it takes the synchronous reset
  // directly; a clear must empty the board in a single cycle.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      height <= '0;
    end else if (inc && !full) begin
      height <= height + 1'b1;
    end else if (dec && !empty) begin
      height <= height - 1'b1;
    end
  end

endmodule

// File: rtl/column_slot_allocator.sv
// -----------------------------------------------------------------------------
// column_slot_allocator
// Tracks the fill height of every Connect4 column. A drop request returns the
// linear cell index where the disc lands; an undo request returns the cell
// vacated by removing the top disc. Rejected operations leave heights intact.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; clears heights and responses
//   bus   : column_slot_allocator_if.slave
//           drop_req/undo_req/clear_board/sel_col in,
//           rsp_valid/rsp_ok/cell_index/cell_row/cell_col out (registered,
//           one cycle after the request),
//           col_full/board_full out (combinational from the heights)
// Cell index = row * NUM_COLS + col, row 0 at the bottom.
// -----------------------------------------------------------------------------
module column_slot_allocator
  import connect4_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic                    clk,
  input  logic                    reset,
  column_slot_allocator_if.slave  bus
);

  // Derived widths are local so they always follow the geometry.
  localparam int IDX_W = $clog2(NUM_COLS * NUM_ROWS);
  localparam int HGT_W = $clog2(NUM_ROWS + 1);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [MAX_COLS-1:0] sel_wide;
  onehot_idx_t         sel;
  op_e                 op;

  assign sel_wide = MAX_COLS'(bus.sel_col);
  assign sel      = onehot_to_idx(sel_wide);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    op = OP_NONE;
    if (bus.drop_req && bus.undo_req) begin
      op = OP_BAD;
    end else if (bus.drop_req || bus.undo_req) begin
      if (!sel.valid)        op = OP_BAD;
      else if (bus.drop_req) op = OP_DROP;
      else                   op = OP_UNDO;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-column height counters
  // ---------------------------------------------------------------------------
  logic [HGT_W-1:0]    heights [NUM_COLS];
  logic [NUM_COLS-1:0] full_vec;
  logic [NUM_COLS-1:0] empty_vec;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic col_hit;
    assign col_hit = (sel.idx == MAX_IDX_W'(c));

    column_height_counter #(
      .NUM_ROWS (NUM_ROWS),
      .HGT_W    (HGT_W)
    ) u_height (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.clear_board),
      .inc    ((op == OP_DROP) && col_hit),
      .dec    ((op == OP_UNDO) && col_hit),
      .height (heights[c]),
      .full   (full_vec[c]),
      .empty  (empty_vec[c])
    );
  end

  assign bus.col_full   = full_vec;
  assign bus.board_full = &full_vec;

  // ---------------------------------------------------------------------------
  // Selected column state
  // ---------------------------------------------------------------------------
  logic [HGT_W-1:0] sel_height;
  logic             sel_full;
  logic             sel_empty;

  always_comb begin
    sel_height = '0;
    sel_full   = 1'b0;
    sel_empty  = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (sel.idx == MAX_IDX_W'(c)) begin
        sel_height = heights[c];
        sel_full   = full_vec[c];
        sel_empty  = empty_vec[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response computation
  // ---------------------------------------------------------------------------
  logic             ok_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic [IDX_W-1:0] idx_d;

  // A rejected drop still reports the column's top cell and a rejected undo
  // its bottom cell, so the caller can see which slot blocked the move.
  always_comb begin
    ok_d  = 1'b0;
    row_d = '0;
    col_d = COL_W'(sel.idx);
    unique case (op)
      OP_DROP: begin
        ok_d  = !sel_full;
        row_d = sel_full ? ROW_W'(NUM_ROWS - 1) : ROW_W'(sel_height);
      end
      OP_UNDO: begin
        ok_d  = !sel_empty;
        row_d = sel_empty ? '0 : ROW_W'(sel_height - 1'b1);
      end
      OP_BAD: begin
        col_d = '0;
      end
      default: begin
        col_d = '0;
      end
    endcase
  end

  // Computed at IDX_W so the product cannot truncate for any legal geometry.
  assign idx_d = IDX_W'(row_d) * IDX_W'(NUM_COLS) + IDX_W'(col_d);

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || bus.clear_board) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_ok     <= 1'b0;
      bus.cell_index <= '0;
      bus.cell_row   <= '0;
      bus.cell_col   <= '0;
    end else if (op != OP_NONE) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_ok     <= ok_d;
      bus.cell_index <= idx_d;
      bus.cell_row   <= row_d;
      bus.cell_col   <= col_d;
    end else begin
      // Idle cycle: the pulse drops, the last cell coordinates stay visible.
      bus.rsp_valid  <= 1'b0;
      bus.rsp_ok     <= 1'b0;
    end
  end

endmodule

// File: doc/column_slot_allocator.md
Name: column_slot_allocator

Overview:
- Parametrised successor of the 4x4 column-drop calculator for Connect4.
- Tracks the fill height of every board column; on a drop request for a one-hot column, returns the linear cell index where the disc lands.
- Adds an undo operation, full and invalid rejection, and board-full flags.
- Sits between the column-select input logic and the board memory / win checker.

Parameters:
- NUM_COLS, 7, number of board columns (2..16).
- NUM_ROWS, 6, number of board rows (2..16).
- IDX_W, $clog2(NUM_COLS*NUM_ROWS), width of the linear cell index (derived; do not override).
- HGT_W, $clog2(NUM_ROWS+1), width of each column height counter (derived).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all heights and outputs.
- drop_req  in  1  single-cycle strobe; request to drop into sel_col.
- undo_req  in  1  single-cycle strobe; remove the top disc of sel_col.
- clear_board  in  1  synchronous board clear; same effect as reset.
- sel_col  in  NUM_COLS  one-hot column select, sampled with drop_req/undo_req.
- rsp_valid  out  1  one-cycle pulse; response for the previous-cycle request.
- rsp_ok  out  1  1 = operation performed; 0 = rejected.
- cell_index  out  IDX_W  row*NUM_COLS+col of the cell filled (drop) or vacated (undo).
- cell_row  out  $clog2(NUM_ROWS)  row of that cell; row 0 is the bottom.
- cell_col  out  $clog2(NUM_COLS)  column of that cell.
- col_full  out  NUM_COLS  bit c = column c height equals NUM_ROWS.
- board_full  out  1  all col_full bits set.

Behaviour:
- Reset/clear: all heights 0; rsp_valid, rsp_ok, cell_index, cell_row, cell_col 0; col_full 0, board_full 0. Reset has priority over everything. clear_board has priority over drop/undo in the same cycle.
- Latency: request sampled at edge N; response registered and visible after edge N, valid for exactly one cycle. No back-pressure; a new request is accepted every cycle.
- Drop, sel_col valid one-hot bit c with height h < NUM_ROWS:
  - cell_row=h, cell_col=c, cell_index=h*NUM_COLS+c, rsp_ok=1.
  - height[c] becomes h+1.
- Drop into a full column (h == NUM_ROWS): rsp_ok=0, height unchanged. cell_* report the top cell (NUM_ROWS-1, c).
- Undo, valid one-hot bit c with h > 0:
  - height[c] becomes h-1.
  - cell_row=h-1, index computed on the same rule, rsp_ok=1.
- Undo on an empty column: rsp_ok=0, height unchanged, cell_* = (0, c).
- Invalid sel_col (zero bits or more than one bit set) with any request: rsp_valid=1, rsp_ok=0, cell_* = 0, no state change.
- drop_req and undo_req asserted together: treated as invalid (rsp_ok=0, no change).
- No request: rsp_valid=0; cell_* hold their last values.
- Counters never wrap: saturate at 0 and NUM_ROWS by rejection.
- Flag timing: col_full and board_full are combinational from the height registers, so they update in the same cycle as rsp_valid.
- Index arithmetic is computed at IDX_W width, so there is no truncation for legal parameters.

Decomposition:
- connect4_pkg holds:
  - default NUM_COLS/NUM_ROWS constants;
  - an op enum (OP_NONE, OP_DROP, OP_UNDO, OP_BAD);
  - a function onehot_to_idx returning the index plus a valid bit.
- Sub-module column_height_counter (HGT_W-bit saturating up/down counter with full/empty outputs) is instantiated NUM_COLS times via generate.

Test Plan:
- After reset, drop col 0 three times (sel_col=7'b0000001) -> indices 0, 7, 14; rows 0, 1, 2; rsp_ok=1 each.
- Drop col 6 six times, then a 7th -> indices 6, 13, 20, 27, 34, 41, then rsp_ok=0 with index 41. col_full=7'b1000000.
- Drop col 3 twice, undo col 3 twice, undo a third time -> undo indices 10, 3, then rsp_ok=0; height 0.
- sel_col=7'b0000110 with drop_req; also drop_req+undo_req together -> rsp_valid=1, rsp_ok=0, heights unchanged.
- Fill all 42 cells -> board_full=1 after the 42nd response. clear_board same cycle as a drop -> no response, all heights 0.
- Assert reset mid-sequence with drop_req high -> next cycle rsp_valid=0, the next drop to col 0 returns index 0.
